// File: rtl/e_pow_engine.sv
// e_pow_engine: computes (1 + 2^-k)^(2^k) as WORDS x 16-bit fixed point by k repeated squarings
// on one sequential 16x16 multiply-accumulate datapath. Word WORDS-1 is the integer part.
// Optional macro E_POW_ROUND_EN: round-half-up at each write-back instead of truncation.
module e_pow_engine #(
  parameter int unsigned WORDS = 32,
  parameter int unsigned KW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] log2_n,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   result [0:WORDS-1]
);

  localparam int unsigned F  = 16 * (WORDS - 1);  // fraction bits
  localparam int unsigned WW = 16 * WORDS;        // work register width
  localparam int unsigned AW = 32 * WORDS;        // accumulator width
  localparam int unsigned IW = $clog2(WORDS);

  localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);
  localparam logic [WW-1:0] OneF    = {16'd1, {F{1'b0}}};  // 1.0 in work format

  typedef enum logic [2:0] {StIdle, StLoad, StMac, StWb, StDone} state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [KW-1:0]          rounds_q, rounds_d;
  logic                   range_err_q, range_err_d;
  logic [IW-1:0]          i_q, i_d, j_q, j_d;
  logic [WORDS-1:0][15:0] work_q, work_d;
  logic [WORDS-1:0][15:0] result_q, result_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [31:0]   prod;
  logic [IW:0]   off;
  logic [AW-1:0] addend;
  logic [WW-1:0] load_val;
  logic [WW-1:0] wb_val;
  logic          k_too_big;

  // Top accumulator word is always zero for legal k and the low fraction bits are discarded.
  logic unused_acc_bits;
  assign unused_acc_bits = ^{acc_q[AW-1 -: 16], acc_q[F-1:0]};

  assign k_too_big = 32'(log2_n) > 32'(F);

  // Datapath: limb product aligned at word offset i+j, load value and write-back value
  always_comb begin
    prod     = {16'b0, work_q[i_q]} * {16'b0, work_q[j_q]};
    off      = {1'b0, i_q} + {1'b0, j_q};
    addend   = {{(AW-32){1'b0}}, prod} << {off, 4'b0000};
    // 1 + 2^-k; for k = 0 the shifted term lands on the integer bit, giving 2.0
    load_val = OneF + (OneF >> k_q);
`ifdef E_POW_ROUND_EN
    wb_val   = acc_q[F +: WW] + {{(WW-1){1'b0}}, acc_q[F-1]};
`else
    wb_val   = acc_q[F +: WW];
`endif
  end

  // Next-state logic for the controller, datapath registers and registered outputs
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rounds_d    = rounds_q;
    range_err_d = range_err_q;
    i_d         = i_q;
    j_d         = j_q;
    work_d      = work_q;
    result_d    = result_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          k_d         = log2_n;
          range_err_d = k_too_big;
          busy_d      = 1'b1;
          state_d     = StLoad;
        end
      end

      StLoad: begin
        rounds_d = k_q;
        i_d      = '0;
        j_d      = '0;
        if (range_err_q) begin
          result_d = '0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = StDone;
        end else if (k_q == '0) begin
          work_d   = load_val;
          result_d = load_val;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          work_d  = load_val;
          acc_d   = '0;
          state_d = StMac;
        end
      end

      StMac: begin
        acc_d = acc_q + addend;
        if (j_q == LastIdx) begin
          j_d = '0;
          if (i_q == LastIdx) begin
            i_d     = '0;
            state_d = StWb;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end

      StWb: begin
        work_d   = wb_val;
        rounds_d = rounds_q - 1'b1;
        if (rounds_q == KW'(1)) begin
          // Result is published on DONE entry so it appears together with done
          result_d = wb_val;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          acc_d   = '0;
          state_d = StMac;
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; async active-low reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      rounds_q    <= '0;
      range_err_q <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      work_q      <= '0;
      result_q    <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      rounds_q    <= rounds_d;
      range_err_q <= range_err_d;
      i_q         <= i_d;
      j_q         <= j_d;
      work_q      <= work_d;
      result_q    <= result_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  // Unpack the registered result onto the word-array port
  always_comb begin
    for (int w = 0; w < WORDS; w++) begin
      result[w] = result_q[w];
    end
  end

endmodule

// File: tb/tb_e_pow_engine.sv
// tb_e_pow_engine: scoreboard bench for e_pow_engine with a WORDS=2 and a WORDS=32 instance.
// Expected values come from a big-integer squaring model (rounding variant under E_POW_ROUND_EN).
module tb_e_pow_engine;

  localparam int KW = 8;

  typedef struct {
    logic [511:0] val;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start2 = 1'b0;
  logic          start32 = 1'b0;
  logic [KW-1:0] k2 = '0;
  logic [KW-1:0] k32 = '0;
  logic          busy2, done2, err2;
  logic          busy32, done32, err32;
  logic [15:0]   res2 [0:1];
  logic [15:0]   res32 [0:31];
  logic [31:0]   flat2;
  logic [511:0]  flat32;

  exp_t q2[$];
  exp_t q32[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done2 = 0;
  int   d0;

  e_pow_engine #(.WORDS(2), .KW(KW)) u_dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start2),
    .log2_n (k2),
    .busy   (busy2),
    .done   (done2),
    .err    (err2),
    .result (res2)
  );

  e_pow_engine #(.WORDS(32), .KW(KW)) u_dut32 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start32),
    .log2_n (k32),
    .busy   (busy32),
    .done   (done32),
    .err    (err32),
    .result (res32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    flat2 = {res2[1], res2[0]};
  end

  always_comb begin
    flat32 = '0;
    for (int w = 0; w < 32; w++) flat32[16*w +: 16] = res32[w];
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Golden model: exact k-fold squaring of 1 + 2^-k, floor (or half-up) to F fraction bits
  function automatic logic [511:0] model(input int words, input int k);
    logic [1023:0] w;
    logic [1023:0] p;
    int            f;
    f = 16 * (words - 1);
    if (k > f) return '0;
    w = (1024'(1) << f) + (1024'(1) << (f - k));
    for (int r = 0; r < k; r++) begin
      p = w * w;
`ifdef E_POW_ROUND_EN
      w = (p >> f) + ((p >> (f - 1)) & 1024'(1));
`else
      w = p >> f;
`endif
    end
    return w[511:0];
  endfunction

  // Scoreboard for the WORDS=2 instance
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done2 || err2) begin
      if (q2.size() == 0) begin
        check_eq("w2 unexpected done", 512'({done2, err2}), 512'(0));
      end else begin
        e = q2.pop_front();
        check_eq("w2 done", 512'(done2), 512'(1));
        check_eq("w2 err", 512'(err2), 512'(e.err));
        check_eq("w2 busy at done", 512'(busy2), 512'(1));
        check_eq("w2 result", 512'(flat2), e.val);
        check_eq("w2 latency", 512'(cyc - e.t0), 512'(e.lat));
      end
    end
    if (done2) n_done2++;
  end

  // Scoreboard for the WORDS=32 instance
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done32 || err32) begin
      if (q32.size() == 0) begin
        check_eq("w32 unexpected done", 512'({done32, err32}), 512'(0));
      end else begin
        e = q32.pop_front();
        check_eq("w32 err", 512'(err32), 512'(e.err));
        check_eq("w32 result", flat32, e.val);
        check_eq("w32 latency", 512'(cyc - e.t0), 512'(e.lat));
      end
    end
  end

  task automatic issue2(input int k);
    exp_t e;
    @(negedge clk);
    start2 = 1'b1;
    k2     = KW'(k);
    e.val  = model(2, k);
    e.err  = (k > 16);
    e.lat  = (k == 0 || k > 16) ? 1 : 1 + k * 5;
    e.t0   = cyc + 1;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic issue32(input int k);
    exp_t e;
    @(negedge clk);
    start32 = 1'b1;
    k32     = KW'(k);
    e.val   = model(32, k);
    e.err   = 1'b0;
    e.lat   = (k == 0) ? 1 : 1 + k * 1025;
    e.t0    = cyc + 1;
    q32.push_back(e);
    @(negedge clk);
    start32 = 1'b0;
  endtask

  // Wait for all outstanding results, then confirm busy has dropped the cycle after DONE
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q2.size() != 0 || q32.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain pending", 512'(q2.size() + q32.size()), 512'(0));
    q2.delete();
    q32.delete();
    #2;
    check_eq("busy2 after done", 512'(busy2), 512'(0));
    check_eq("busy32 after done", 512'(busy32), 512'(0));
    check_eq("done2 one pulse", 512'(done2), 512'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset busy", 512'({busy2, busy32}), 512'(0));
    check_eq("reset done", 512'({done2, done32}), 512'(0));
    check_eq("reset err", 512'({err2, err32}), 512'(0));
    check_eq("reset res2", 512'(flat2), 512'(0));
    check_eq("reset res32", flat32, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;

    issue2(0);
    wait_drain(20);
    check_eq("k0 value", 512'(flat2), 512'(32'h0002_0000));

    issue2(1);
    wait_drain(20);
    check_eq("k1 value", 512'(flat2), 512'(32'h0002_4000));

    // Re-pulse start mid-computation: must be ignored and the old result held
    d0 = n_done2;
    issue2(2);
    repeat (3) @(negedge clk);
    start2 = 1'b1;
    k2     = KW'(5);
    @(negedge clk);
    start2 = 1'b0;
    check_eq("result held busy", 512'(flat2), 512'(32'h0002_4000));
    check_eq("busy mid run", 512'(busy2), 512'(1));
    wait_drain(40);
    check_eq("k2 value", 512'(flat2), 512'(32'h0002_7100));
    repeat (12) @(posedge clk);
    check_eq("single done", 512'(n_done2 - d0), 512'(1));

    issue2(17);
    wait_drain(20);

    issue2(16);
    wait_drain(120);

    // Asynchronous reset in the middle of a k=3 run
    issue2(3);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q2.delete();
    #1;
    check_eq("mid reset busy", 512'(busy2), 512'(0));
    check_eq("mid reset done", 512'(done2), 512'(0));
    check_eq("mid reset result", 512'(flat2), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue2(3);
    wait_drain(40);

    issue32(15);
    wait_drain(16000);
    check_eq("w32 int word", 512'(flat32[511:496]), 512'(16'h0002));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
